// File: rtl/dvp_pixel_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pixel_tx_if
//  Purpose  : Bundles the RGB565 pixel stream and the DVP output bus of the
//             DVP pixel transmitter.
//  Signals  : pix_data/pix_valid/pix_ready  - pixel stream (valid/ready)
//             dvp_vsync/dvp_href/dvp_data   - 8-bit DVP byte bus
//             frame_start/underrun/underrun_sticky - status
//  Modports : master - transmitter side (consumes pixels, drives DVP)
//             slave  - pixel source / DVP sink side
//  Revision : 1.0 - initial release
// ============================================================================
interface dvp_pixel_tx_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;
  logic        frame_start;
  logic        underrun;
  logic        underrun_sticky;

  modport master (
    input  pix_data, pix_valid,
    output pix_ready, dvp_vsync, dvp_href, dvp_data,
    output frame_start, underrun, underrun_sticky
  );

  modport slave (
    output pix_data, pix_valid,
    input  pix_ready, dvp_vsync, dvp_href, dvp_data,
    input  frame_start, underrun, underrun_sticky
  );
endinterface
`default_nettype wire

// File: rtl/dvp_pixel_tx.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pixel_tx
//  Purpose  : Camera emulator. Accepts RGB565 pixels on a valid/ready stream
//             and emits a free-running OV5640-style DVP stream (vsync, href,
//             8-bit data, high byte first).
//  Ports    : pclk - byte clock, rst - synchronous active-high reset,
//             en   - frame enable (sampled in IDLE and at frame end),
//             bus  - dvp_pixel_tx_if.master (pixel stream + DVP + status)
//  Revision : 1.0 - initial release
// ============================================================================
module dvp_pixel_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 288,
  parameter int V_ACTIVE = 480,
  parameter int VS_LINES = 4,
  parameter int V_BACK   = 16,
  parameter int V_FRONT  = 8
) (
  input  logic           pclk,
  input  logic           rst,
  input  logic           en,
  dvp_pixel_tx_if.master bus
);

  localparam int LINE_CLKS = 2 * H_ACTIVE + H_BLANK;
  localparam int MAX_VS_VB = (VS_LINES > V_BACK)  ? VS_LINES : V_BACK;
  localparam int MAX_VA_VF = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_LINES = (MAX_VS_VB > MAX_VA_VF) ? MAX_VS_VB : MAX_VA_VF;
  localparam int H_W       = (LINE_CLKS > 1) ? $clog2(LINE_CLKS) : 1;
  localparam int L_W       = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  // Zero-length vertical regions are skipped by resolving the successor
  // state at elaboration time.
  localparam state_t FIRST_STATE = (VS_LINES > 0) ? S_VSYNC :
                                   ((V_BACK > 0) ? S_VBACK : S_ACTIVE);
  localparam state_t AFTER_VSYNC = (V_BACK > 0) ? S_VBACK : S_ACTIVE;

  state_t         state_q, state_d;
  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [L_W-1:0] line_cnt_q, line_cnt_d;
  logic           vsync_q, vsync_d;
  logic           href_q, href_d;
  logic [7:0]     data_q, data_d;
  logic [7:0]     lo_q, lo_d;
  logic           frame_start_q, frame_start_d;
  logic           sticky_q, sticky_d;

  logic frame_begin;
  logic state_done;
  logic hi_slot;
  logic pix_ready;
  logic accept;
  logic underrun;
  int   cur_lines;

  // Position sequencer: state_q/h_cnt_q/line_cnt_q describe the clock whose
  // bytes are currently on the bus; *_d is the position of the next clock.
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    line_cnt_d  = line_cnt_q;
    frame_begin = 1'b0;

    case (state_q)
      S_VSYNC:  cur_lines = VS_LINES;
      S_VBACK:  cur_lines = V_BACK;
      S_ACTIVE: cur_lines = V_ACTIVE;
      S_VFRONT: cur_lines = V_FRONT;
      default:  cur_lines = 1;
    endcase
    state_done = (int'(h_cnt_q) == LINE_CLKS - 1) &&
                 (int'(line_cnt_q) == cur_lines - 1);

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d     = FIRST_STATE;
          frame_begin = 1'b1;
        end
      end
      S_VSYNC: begin
        if (state_done) state_d = AFTER_VSYNC;
      end
      S_VBACK: begin
        if (state_done) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (state_done) begin
          if (V_FRONT > 0) begin
            state_d = S_VFRONT;
          end else begin
            state_d     = en ? FIRST_STATE : S_IDLE;
            frame_begin = en;
          end
        end
      end
      S_VFRONT: begin
        if (state_done) begin
          state_d     = en ? FIRST_STATE : S_IDLE;
          frame_begin = en;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) begin
      if (int'(h_cnt_q) == LINE_CLKS - 1) begin
        h_cnt_d    = '0;
        line_cnt_d = state_done ? '0 : line_cnt_q + L_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + H_W'(1);
      end
    end
  end

  // Output stage: everything is decoded from the next position so the DVP
  // pins come straight from flops. pix_ready is high when the next clock is a
  // high-byte slot, which gives one clock from handshake to high byte.
  always_comb begin
    href_d        = (state_d == S_ACTIVE) && (int'(h_cnt_d) < 2 * H_ACTIVE);
    hi_slot       = href_d && !h_cnt_d[0];
    pix_ready     = hi_slot && !rst;
    accept        = pix_ready && bus.pix_valid;
    underrun      = pix_ready && !bus.pix_valid;
    vsync_d       = (state_d == S_VSYNC);
    frame_start_d = frame_begin;
    sticky_d      = sticky_q || underrun;
    lo_d          = lo_q;
    data_d        = 8'h00;
    if (hi_slot) begin
      // A missed slot still consumes its two byte clocks, sent as zeros.
      data_d = accept ? bus.pix_data[15:8] : 8'h00;
      lo_d   = accept ? bus.pix_data[7:0]  : 8'h00;
    end else if (href_d) begin
      data_d = lo_q;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      h_cnt_q       <= '0;
      line_cnt_q    <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      data_q        <= 8'h00;
      lo_q          <= 8'h00;
      frame_start_q <= 1'b0;
      sticky_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      line_cnt_q    <= line_cnt_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      data_q        <= data_d;
      lo_q          <= lo_d;
      frame_start_q <= frame_start_d;
      sticky_q      <= sticky_d;
    end
  end

  assign bus.pix_ready       = pix_ready;
  assign bus.dvp_vsync       = vsync_q;
  assign bus.dvp_href        = href_q;
  assign bus.dvp_data        = data_q;
  assign bus.frame_start     = frame_start_q;
  assign bus.underrun        = underrun;
  assign bus.underrun_sticky = sticky_q;

endmodule
`default_nettype wire
